// File: rtl/block_nonblock_pkg.sv
// Shared constants for block_nonblock: default operand width, sum width helper
// and the output latency of each build flavour.
package block_nonblock_pkg;

  localparam int WIDTH_DEF  = 1;
  localparam int SUM_W      = WIDTH_DEF + 1;
  localparam int LAT_SINGLE = 1;
  localparam int LAT_PIPE   = 2;

  // One extra bit is enough to hold a+b without loss.
  function automatic int sum_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/block_nonblock_if.sv
// Operand/result bundle for block_nonblock, used by the driving side and the
// consuming side of the adder.
interface block_nonblock_if #(
  parameter int WIDTH = 1
);

  logic             Rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH:0]   out;

  modport master (output Rst, output a, output b, output c, input out);
  modport slave  (input Rst, input a, input b, input c, output out);

endinterface

// File: rtl/bn_add_stage.sv
// Registered two-operand adder with asynchronous active-low reset to zero;
// the sum wraps at the operand width.
module bn_add_stage #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_d;
  logic [W-1:0] sum_q;

  always_comb begin
    sum_d = x + y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/block_nonblock.sv
// Registered three-operand adder out = (a+b+c) mod 2^(WIDTH+1). Defining
// PIPELINE_EN splits it into two register stages (a+b first, then +c).
module block_nonblock
  import block_nonblock_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH:0]   out
);

  localparam int SW = sum_w(WIDTH);

  logic [SW-1:0] a_ext;
  logic [SW-1:0] b_ext;
  logic [SW-1:0] c_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign c_ext = {1'b0, c};

`ifdef PIPELINE_EN
  logic [SW-1:0] d_q;
  logic [SW-1:0] c_dly_d;
  logic [SW-1:0] c_dly_q;

  bn_add_stage #(.W(SW)) u_stage_ab (
    .clk   (Clk),
    .rst_n (Rst),
    .x     (a_ext),
    .y     (b_ext),
    .sum   (d_q)
  );

  // c travels alongside its own a+b so the second stage adds matching operands.
  always_comb begin
    c_dly_d = c_ext;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      c_dly_q <= '0;
    end else begin
      c_dly_q <= c_dly_d;
    end
  end

  bn_add_stage #(.W(SW)) u_stage_out (
    .clk   (Clk),
    .rst_n (Rst),
    .x     (d_q),
    .y     (c_dly_q),
    .sum   (out)
  );
`else
  logic [SW-1:0] ab_sum;

  always_comb begin
    ab_sum = a_ext + b_ext;
  end

  bn_add_stage #(.W(SW)) u_stage_out (
    .clk   (Clk),
    .rst_n (Rst),
    .x     (ab_sum),
    .y     (c_ext),
    .sum   (out)
  );
`endif

endmodule

// File: tb/tb_block_nonblock.sv
// Scoreboard bench for block_nonblock: each issued operand set queues its
// expected sum with the edge it must appear after; a monitor checks every cycle.
module tb_block_nonblock;
  import block_nonblock_pkg::*;

  localparam int WIDTH = WIDTH_DEF;
`ifdef PIPELINE_EN
  localparam int LAT = LAT_PIPE;
`else
  localparam int LAT = LAT_SINGLE;
`endif

  typedef struct {
    int value;
    int due;
  } exp_t;

  logic Clk;
  int   testsRun     = 0;
  int   testsFailed  = 0;
  int   edgeCount    = 0;
  int   lastExpected = 0;
  int   maxOperand   = (1 << WIDTH) - 1;
  exp_t expQ[$];

  block_nonblock_if #(.WIDTH(WIDTH)) bus ();

  block_nonblock #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (bus.Rst),
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .out (bus.out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    forever begin
      @(posedge Clk);
      edgeCount++;
    end
  end

  task automatic checkOutput(input string name, input int expected);
    logic [WIDTH:0] expv;
    expv = expected[WIDTH:0];
    testsRun++;
    if (bus.out !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: out=%0d expected=%0d", name, $time, bus.out, expv);
    end
  endtask

  // Inputs change 1 ns after an edge; the next edge samples them.
  task automatic applyStimulus(input logic rstv, input int av, input int bv, input int cv);
    @(posedge Clk);
    #1;
    bus.Rst = rstv;
    bus.a   = av[WIDTH-1:0];
    bus.b   = bv[WIDTH-1:0];
    bus.c   = cv[WIDTH-1:0];
    if (rstv) begin
      expQ.push_back('{value: (av + bv + cv) % (1 << (WIDTH + 1)), due: edgeCount + LAT});
    end
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      while (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
        lastExpected = expQ[0].value;
        void'(expQ.pop_front());
      end
      if (bus.Rst === 1'b1) checkOutput("sum", lastExpected);
      else checkOutput("reset_hold", 0);
    end
  end

  // Reset drops everything in flight and must clear out without a clock edge.
  initial begin
    forever begin
      @(negedge bus.Rst);
      expQ.delete();
      lastExpected = 0;
      #1;
      checkOutput("reset_immediate", 0);
    end
  end

  initial begin
    #200000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    bus.Rst = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.c   = '0;

    repeat (10) applyStimulus(1'b0, 0, 0, 0);
    repeat (10) applyStimulus(1'b0, $urandom_range(0, maxOperand),
                              $urandom_range(0, maxOperand), $urandom_range(0, maxOperand));

    for (int combo = 0; combo < 8; combo++) begin
      repeat (10) applyStimulus(1'b1, (combo >> 2) & 1, (combo >> 1) & 1, combo & 1);
    end

    repeat (20) applyStimulus(1'b1, maxOperand, maxOperand, maxOperand);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 0, 0, 0);
      else applyStimulus(1'b1, 1, 1, 1);
    end

    repeat (150) applyStimulus(1'b1, $urandom_range(0, maxOperand),
                               $urandom_range(0, maxOperand), $urandom_range(0, maxOperand));

    repeat (5) applyStimulus(1'b1, 1, 1, 1);
    @(posedge Clk);
    #3;
    bus.Rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 1, 1, 1);
    repeat (10) applyStimulus(1'b1, 1, 1, 1);

    repeat (LAT + 2) @(posedge Clk);
    @(negedge Clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
